// File: rtl/tx_serial_elevador_pkg.sv
// Shared definitions for the elevator serial transmitter: state encodings,
// frame-length constants and counter sizing helpers.
package tx_serial_elevador_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRANSMITE = 2'd1,
      FINAL     = 2'd2
   } estado_t;

   localparam int BAUD_DIV_PADRAO    = 434;
   localparam int NBITS_SEM_PARIDADE = 10;
   localparam int NBITS_COM_PARIDADE = 11;

   function automatic int calc_nbits(input int stop_bits, input int paridade);
      return NBITS_SEM_PARIDADE + paridade + stop_bits - 1;
   endfunction

   // A divider of 1 would give $clog2 = 0; keep at least one bit.
   function automatic int largura_baud(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tx_serial_elevador_contador_baud_tick.sv
// Mod-DIV counter with synchronous clear and a tick at terminal count.
// Shared between the serial transmitter and the planned serial receiver.
module contador_baud_tick
   import tx_serial_elevador_pkg::*;
#(
   parameter int DIV = BAUD_DIV_PADRAO
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic habilita,
   output logic tick
);

   localparam int W = largura_baud(DIV);
   localparam logic [W-1:0] TERMINAL = W'(DIV - 1);

   logic [W-1:0] contagem;

   assign tick = habilita && (contagem == TERMINAL);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contagem <= '0;
      end else if (limpa) begin
         contagem <= '0;
      end else if (habilita) begin
         if (contagem == TERMINAL) begin
            contagem <= '0;
         end else begin
            contagem <= contagem + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_serial_elevador.sv
// UART-style transmitter for the elevator auto-send unit: start, 8 data bits LSB first,
// optional even parity (macro TX_SERIAL_PARITY_EN), STOP_BITS stop bits.
module tx_serial_elevador
   import tx_serial_elevador_pkg::*;
#(
   parameter int BAUD_DIV  = BAUD_DIV_PADRAO,
   parameter int STOP_BITS = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dados,
   output logic       saida_serial,
   output logic       enviado,
   output logic       ocupado
);

`ifdef TX_SERIAL_PARITY_EN
   localparam int PARIDADE = 1;
`else
   localparam int PARIDADE = 0;
`endif

   localparam int NBITS   = calc_nbits(STOP_BITS, PARIDADE);
   localparam int LARG_SR = NBITS - 1;
   localparam logic [3:0] ULTIMO_BIT = 4'(NBITS - 1);

   estado_t              estado;
   logic [LARG_SR-1:0]   desloca;
   logic [LARG_SR-1:0]   carga;
   logic [3:0]           cont_bits;
   logic                 tick;
   logic                 em_transmissao;

   assign em_transmissao = (estado == TRANSMITE);

   contador_baud_tick #(
      .DIV (BAUD_DIV)
   ) u_contador_baud (
      .clock    (clock),
      .reset    (reset),
      .limpa    (!em_transmissao),
      .habilita (em_transmissao),
      .tick     (tick)
   );

   // Everything after the start bit; the start bit goes straight onto the line.
   always_comb begin
      carga = '1;
`ifdef TX_SERIAL_PARITY_EN
      carga = {{STOP_BITS{1'b1}}, ^dados, dados};
`else
      carga = {{STOP_BITS{1'b1}}, dados};
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado       <= IDLE;
         saida_serial <= 1'b1;
         enviado      <= 1'b0;
         ocupado      <= 1'b0;
         desloca      <= '0;
         cont_bits    <= '0;
      end else begin
         case (estado)
            IDLE: begin
               saida_serial <= 1'b1;
               enviado      <= 1'b0;
               ocupado      <= 1'b0;
               if (partida) begin
                  desloca      <= carga;
                  cont_bits    <= '0;
                  saida_serial <= 1'b0;
                  ocupado      <= 1'b1;
                  estado       <= TRANSMITE;
               end
            end
            TRANSMITE: begin
               if (tick) begin
                  if (cont_bits == ULTIMO_BIT) begin
                     saida_serial <= 1'b1;
                     enviado      <= 1'b1;
                     estado       <= FINAL;
                  end else begin
                     saida_serial <= desloca[0];
                     desloca      <= {1'b1, desloca[LARG_SR-1:1]};
                     cont_bits    <= cont_bits + 1'b1;
                  end
               end
            end
            FINAL: begin
               saida_serial <= 1'b1;
               enviado      <= 1'b0;
               ocupado      <= 1'b0;
               estado       <= IDLE;
            end
            default: begin
               saida_serial <= 1'b1;
               enviado      <= 1'b0;
               ocupado      <= 1'b0;
               estado       <= IDLE;
            end
         endcase
      end
   end

endmodule
